// File: rtl/seg_scan_decoder.sv
// Monitors the scanned seg/an pins of a 4-digit common-anode display and
// rebuilds the BCD digits shown, publishing each complete frame atomically.
module seg_scan_decoder #(
    parameter int STABLE = 4,
    parameter int TO_W   = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg,
    input  logic [3:0] an,
    output logic [3:0] D0,
    output logic [3:0] D1,
    output logic [3:0] D2,
    output logic [3:0] D3,
    output logic       frame_valid,
    output logic [3:0] digit_err,
    output logic       an_err,
    output logic       stale
);

    localparam int                CNT_W   = $clog2(STABLE + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  ACC_CNT = CNT_W'(STABLE - 2);
    localparam logic [TO_W-1:0]   TO_MAX  = {TO_W{1'b1}};

    // Sample layout: {an[3:0], seg[6:0]}; dp never reaches the sampler.
    logic [10:0]      sync1_q, sync1_d;
    logic [10:0]      samp_q, samp_d;
    logic [10:0]      prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accepted_q, accepted_d;
    logic [3:0]       got_q, got_d;
    logic [3:0]       shadow_q [4];
    logic [3:0]       shadow_d [4];
    logic [3:0]       shadow_err_q, shadow_err_d;
    logic [3:0]       dout_q [4];
    logic [3:0]       dout_d [4];
    logic [3:0]       digit_err_q, digit_err_d;
    logic             frame_valid_q, frame_valid_d;
    logic             an_err_q, an_err_d;
    logic [TO_W-1:0]  to_q, to_d;

    logic             changed;
    logic             an_single;
    logic             an_illegal;
    logic             accept;
    logic             publish;
    logic [1:0]       sel;
    logic [4:0]       dec;
    logic             unused_dp;

    assign unused_dp = seg[7];

    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = {1'b0, 4'd0};
            7'h79:   r = {1'b0, 4'd1};
            7'h24:   r = {1'b0, 4'd2};
            7'h30:   r = {1'b0, 4'd3};
            7'h19:   r = {1'b0, 4'd4};
            7'h12:   r = {1'b0, 4'd5};
            7'h02:   r = {1'b0, 4'd6};
            7'h78:   r = {1'b0, 4'd7};
            7'h00:   r = {1'b0, 4'd8};
            7'h10:   r = {1'b0, 4'd9};
            7'h7F:   r = {1'b0, 4'hE};
            default: r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    function automatic logic [1:0] anode_index(input logic [3:0] a_n);
        logic [1:0] r;
        case (a_n)
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        sync1_d = {an, seg[6:0]};
        samp_d  = sync1_q;
        prev_d  = samp_q;

        changed    = (samp_q != prev_q);
        an_single  = $onehot(~samp_q[10:7]);
        an_illegal = !an_single && (samp_q[10:7] != 4'hF);
        sel        = anode_index(samp_q[10:7]);
        dec        = decode_seg(samp_q[6:0]);

        cnt_d = cnt_q;
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // cnt_q == STABLE-2 with an unchanged sample means STABLE identical samples.
        accept     = !changed && !accepted_q && (cnt_q == ACC_CNT) && an_single;
        accepted_d = changed ? 1'b0 : (accepted_q | accept);

        an_err_d = an_err_q | an_illegal;

        publish       = (got_q == 4'hF);
        frame_valid_d = publish;
        got_d         = publish ? 4'h0 : got_q;
        dout_d        = dout_q;
        digit_err_d   = digit_err_q;
        if (publish) begin
            dout_d      = shadow_q;
            digit_err_d = shadow_err_q;
        end

        // An accept in the publish cycle lands in the freshly cleared frame.
        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        if (accept) begin
            got_d[sel]        = 1'b1;
            shadow_d[sel]     = dec[3:0];
            shadow_err_d[sel] = dec[4];
        end

        if (publish) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + TO_W'(1);
        end else begin
            to_d = to_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q       <= '1;
            samp_q        <= '1;
            prev_q        <= '1;
            cnt_q         <= '0;
            accepted_q    <= 1'b0;
            got_q         <= 4'h0;
            dout_q        <= '{4'h0, 4'h0, 4'h0, 4'h0};
            digit_err_q   <= 4'h0;
            frame_valid_q <= 1'b0;
            an_err_q      <= 1'b0;
            to_q          <= '0;
        end else begin
            sync1_q       <= sync1_d;
            samp_q        <= samp_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            accepted_q    <= accepted_d;
            got_q         <= got_d;
            dout_q        <= dout_d;
            digit_err_q   <= digit_err_d;
            frame_valid_q <= frame_valid_d;
            an_err_q      <= an_err_d;
            to_q          <= to_d;
        end
    end

    // Shadow contents are only meaningful under got_q, so they need no reset.
    always_ff @(posedge clk) begin
        shadow_q     <= shadow_d;
        shadow_err_q <= shadow_err_d;
    end

    assign D0          = dout_q[0];
    assign D1          = dout_q[1];
    assign D2          = dout_q[2];
    assign D3          = dout_q[3];
    assign digit_err   = digit_err_q;
    assign frame_valid = frame_valid_q;
    assign an_err      = an_err_q;
    assign stale       = (to_q == TO_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scan scenarios plus random dwells,
// checked every cycle against a pin-history reference model.
module tb_seg_scan_decoder;
    localparam int STABLE = 4;
    localparam int TO_W   = 4;
    localparam int TO_MAX = (1 << TO_W) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seg;
    logic [3:0] an;
    logic [3:0] D0, D1, D2, D3;
    logic       frame_valid;
    logic [3:0] digit_err;
    logic       an_err;
    logic       stale;

    seg_scan_decoder #(.STABLE(STABLE), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset), .seg(seg), .an(an),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .frame_valid(frame_valid), .digit_err(digit_err),
        .an_err(an_err), .stale(stale)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   ecount = 0;
    int   fv_count = 0;
    int   last_fv_edge = 0;
    int   last_stale_rise = 0;
    logic prev_stale = 1'b0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h expected=%0h edge=%0d", nm, act, exp, ecount);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        if (p == 7'h7F) return {1'b0, 4'hE};
        for (int k = 0; k < 10; k++)
            if (seg_tab[k] == p) return {1'b0, 4'(k)};
        return {1'b1, 4'hF};
    endfunction

    // Reference model: h[0] is the pin word present at the previous edge,
    // h[1] the one before that (the value the decoder currently sees), etc.
    logic [10:0] h [8];
    logic [3:0]  m_sh [4];
    logic [3:0]  m_she;
    logic [3:0]  m_d [4];
    logic [3:0]  m_err;
    logic        m_anerr;
    logic        m_fv;
    logic [3:0]  m_got;
    int          m_to;

    always @(posedge clk) begin : model
        bit         acc;
        int         nlow;
        int         dsel;
        logic [4:0] dv;
        ecount++;
        if (!reset) begin
            for (int i = 0; i < 8; i++) h[i] = '1;
            for (int i = 0; i < 4; i++) m_d[i] = 4'h0;
            m_err = 4'h0; m_anerr = 1'b0; m_fv = 1'b0; m_got = 4'h0; m_to = 0;
        end else begin
            nlow = 4 - $countones(h[1][10:7]);
            // Accept exactly when a legal value has been seen STABLE times in a row.
            acc = (nlow == 1) && (h[STABLE+1] != h[1]);
            for (int i = 2; i <= STABLE; i++) if (h[i] != h[1]) acc = 1'b0;
            if (nlow >= 2) m_anerr = 1'b1;
            if (m_got == 4'hF) begin
                for (int i = 0; i < 4; i++) m_d[i] = m_sh[i];
                m_err = m_she; m_fv = 1'b1; m_got = 4'h0; m_to = 0;
            end else begin
                m_fv = 1'b0;
                if (m_to < TO_MAX) m_to++;
            end
            if (acc) begin
                dsel = 0;
                for (int i = 0; i < 4; i++) if (!h[1][7+i]) dsel = i;
                dv = ref_decode(h[1][6:0]);
                m_sh[dsel] = dv[3:0]; m_she[dsel] = dv[4]; m_got[dsel] = 1'b1;
            end
            for (int i = 7; i > 0; i--) h[i] = h[i-1];
            h[0] = {an, seg[6:0]};
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("D0", 32'(D0), 32'(m_d[0]));
            chk("D1", 32'(D1), 32'(m_d[1]));
            chk("D2", 32'(D2), 32'(m_d[2]));
            chk("D3", 32'(D3), 32'(m_d[3]));
            chk("digit_err", 32'(digit_err), 32'(m_err));
            chk("an_err", 32'(an_err), 32'(m_anerr));
            chk("frame_valid", 32'(frame_valid), 32'(m_fv));
            chk("stale", 32'(stale), 32'(m_to == TO_MAX));
            if (frame_valid === 1'b1) begin
                fv_count++;
                last_fv_edge = ecount;
            end
            if (stale === 1'b1 && !prev_stale) last_stale_rise = ecount;
            prev_stale = stale;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        step(n);
    endtask

    task automatic frame(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3, input int n);
        dwell(4'b1110, s0, n);
        dwell(4'b1101, s1, n);
        dwell(4'b1011, s2, n);
        dwell(4'b0111, s3, n);
    endtask

    task automatic chk_digits(input string nm, input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3);
        chk({nm, "_D0"}, 32'(D0), 32'(e0));
        chk({nm, "_D1"}, 32'(D1), 32'(e1));
        chk({nm, "_D2"}, 32'(D2), 32'(e2));
        chk({nm, "_D3"}, 32'(D3), 32'(e3));
    endtask

    initial begin : stim
        int base;
        int fv0;
        reset = 1'b0;
        an    = 4'hF;
        seg   = 8'hFF;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_digits("rst", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst_digit_err", 32'(digit_err), 32'h0);
        chk("rst_an_err", 32'(an_err), 32'h0);
        chk("rst_frame_valid", 32'(frame_valid), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);
        reset = 1'b1;

        // Normal frame: D3 accepted at edge 53, publish on edge 54.
        base = ecount;
        fv0  = fv_count;
        frame(8'h19, 8'h30, 8'h24, 8'h79, 16);
        #1;
        chk("t1_frames", 32'(fv_count - fv0), 32'd1);
        chk("t1_latency", 32'(last_fv_edge - base - 1), 32'd54);
        chk_digits("t1", 4'd4, 4'd3, 4'd2, 4'd1);
        chk("t1_digit_err", 32'(digit_err), 32'h0);

        // Short glitch dwell on D1 must not be captured.
        fv0 = fv_count;
        dwell(4'b1110, 8'h19, 16);
        dwell(4'b1101, 8'h30, 16);
        dwell(4'b1101, 8'h00, 3);
        dwell(4'b1011, 8'h24, 16);
        dwell(4'b0111, 8'h79, 16);
        #1;
        chk("t2_frames", 32'(fv_count - fv0), 32'd1);
        chk("t2_D1", 32'(D1), 32'd3);

        // Illegal anode: sticky an_err, no capture.
        fv0 = fv_count;
        dwell(4'b1110, 8'h19, 16);
        dwell(4'b1101, 8'h30, 16);
        dwell(4'b1100, 8'h19, 10);
        #1;
        chk("t3_an_err", 32'(an_err), 32'd1);
        chk("t3_no_frame", 32'(fv_count - fv0), 32'd0);
        dwell(4'b1011, 8'h24, 16);
        dwell(4'b0111, 8'h79, 16);
        #1;
        chk("t3_frames", 32'(fv_count - fv0), 32'd1);
        chk("t3_an_err_hold", 32'(an_err), 32'd1);
        chk_digits("t3", 4'd4, 4'd3, 4'd2, 4'd1);

        // Bad pattern and blank.
        fv0 = fv_count;
        frame(8'h19, 8'h30, 8'h7E, 8'h7F, 16);
        #1;
        chk("t4_frames", 32'(fv_count - fv0), 32'd1);
        chk_digits("t4", 4'd4, 4'd3, 4'hF, 4'hE);
        chk("t4_digit_err", 32'(digit_err), 32'h4);

        // Timeout after scanning stops; a fresh frame clears it.
        frame(8'h19, 8'h30, 8'h24, 8'h79, 16);
        dwell(4'hF, 8'hFF, 30);
        #1;
        chk("t5_stale", 32'(stale), 32'd1);
        chk("t5_stale_delay", 32'(last_stale_rise - last_fv_edge), 32'd15);
        fv0 = fv_count;
        frame(8'h19, 8'h30, 8'h24, 8'h79, 16);
        #1;
        chk("t5_frames", 32'(fv_count - fv0), 32'd1);
        chk("t5_stale_clear", 32'(stale), 32'd0);

        // Reset mid-frame discards the partial frame.
        dwell(4'b1110, 8'h19, 16);
        dwell(4'b1101, 8'h30, 16);
        reset = 1'b0;
        an    = 4'hF;
        seg   = 8'hFF;
        step(1);
        #1;
        chk_digits("t6_rst", 4'h0, 4'h0, 4'h0, 4'h0);
        chk("t6_rst_digit_err", 32'(digit_err), 32'h0);
        chk("t6_rst_an_err", 32'(an_err), 32'h0);
        chk("t6_rst_stale", 32'(stale), 32'h0);
        reset = 1'b1;
        fv0 = fv_count;
        dwell(4'b1011, 8'h24, 16);
        dwell(4'b0111, 8'h79, 16);
        dwell(4'hF, 8'hFF, 10);
        #1;
        chk("t6_no_frame", 32'(fv_count - fv0), 32'd0);
        dwell(4'b1110, 8'h19, 16);
        dwell(4'b1101, 8'h30, 16);
        #1;
        chk("t6_frames", 32'(fv_count - fv0), 32'd1);
        chk_digits("t6", 4'd4, 4'd3, 4'd2, 4'd1);

        // Random dwells: digits, blanks, junk, idle, illegal anodes, resets.
        for (int k = 0; k < 400; k++) begin
            int         r;
            logic [3:0] a;
            logic [6:0] s7;
            if ($urandom_range(0, 99) < 2) begin
                reset = 1'b0;
                step(1);
                reset = 1'b1;
            end
            r = $urandom_range(0, 99);
            if (r < 10)      a = 4'hF;
            else if (r < 15) a = 4'($urandom_range(0, 15));
            else             a = ~(4'b0001 << $urandom_range(0, 3));
            r = $urandom_range(0, 99);
            if (r < 75)      s7 = seg_tab[$urandom_range(0, 9)];
            else if (r < 85) s7 = 7'h7F;
            else             s7 = 7'($urandom_range(0, 127));
            dwell(a, {1'($urandom_range(0, 1)), s7}, $urandom_range(1, 12));
        end
        dwell(4'hF, 8'hFF, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the team's multiplexed 7-segment display driver: watches the scanned `seg`/`an` pins of a 4-digit common-anode display and reconstructs the four BCD digits being shown. Used on the board-level bench and on the FPGA as a self-check monitor behind the timer, so displayed minutes/seconds can be compared against the counter digits. Each anode dwell is filtered for stability, decoded, and collected into a frame. Complete frames are published atomically with a one-cycle strobe.

## Interface
- `STABLE`, 4: consecutive identical synchronized samples required before a digit is accepted (≥2).
- `TO_W`, 20: width of the frame-timeout counter. `stale` asserts when it saturates at 2^TO_W−1.
- `clk` input 1: single system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `seg` input 8: active-low segments. `seg[6:0]` = {g,f,e,d,c,b,a}; `seg[7]` = dp, which is ignored.
- `an` input 4: active-low anodes. `an[0]` selects D0 (rightmost digit) through `an[3]` = D3.
- `D0`, `D1`, `D2`, `D3` output 4 each: last published frame values.
- `frame_valid` output 1: one-cycle strobe when D0–D3 update.
- `digit_err` output 4: per-digit flag. Set when the published value came from an undecodable pattern.
- `an_err` output 1: sticky flag. Set when an illegal anode pattern was seen; cleared only by reset.
- `stale` output 1: high when no frame has completed for 2^TO_W−1 cycles.

## Operation
- Input sync: `seg[6:0]` and `an` pass through two flop stages. The second-stage value is the sample `s`.
- Stability counter `cnt`:
  - Increments (saturating) while `s` equals its previous value.
  - Clears to 0 when `s` changes.
- Anode classification on `s.an`:
  - Exactly one bit low: legal.
  - 4'b1111: idle. No capture; `cnt` still tracks.
  - Two or more bits low: illegal. Sets `an_err`, no capture.
- Capture rules:
  - A legal `s` is accepted on the cycle it has been held for STABLE consecutive samples.
  - At most one accept per dwell. An `accepted` latch is cleared whenever `s` changes.
- Decode (active-low gfedcba):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Blank 7'h7F decodes to 4'hE with no error.
  - Any other pattern decodes to 4'hF and sets that digit's shadow error bit.
- On accept:
  - Write the decoded value and error bit into the shadow register for the selected digit.
  - Set that digit's bit in `got[3:0]`.
  - Re-capturing a digit before the frame completes overwrites its shadow entry (newest wins).
- Frame publish:
  - When `got` == 4'b1111, the next cycle copies shadow values to D0–D3 and shadow error bits to `digit_err`.
  - The same cycle pulses `frame_valid`, clears `got`, and clears the timeout counter.
  - An accept in the publish cycle belongs to the next frame: `got` is cleared, then that accept's bit is set.
- Timeout counter:
  - Increments every cycle and saturates.
  - `stale` = counter saturated.
  - Cleared only by a frame publish or by reset.

## Timing
- Reset values (on a clock edge with `reset` = 0):
  - D0–D3 = 0, `digit_err` = 0, `an_err` = 0, `frame_valid` = 0, `stale` = 0.
  - `got` = 0, `cnt` = 0, timeout counter = 0, sync flops = all-ones (idle).
- Reset mid-frame discards partial `got` and shadow contents. No frame is published until four fresh accepts occur.
- Pin-to-accept latency: 2 cycles of sync, then accept in the cycle where the value has been held for STABLE consecutive samples. That is pin change at edge 0, accept at edge 2+STABLE−1.
- A dwell shorter than STABLE cycles at the pins is never accepted.
- Frame latency: `frame_valid` and updated D outputs appear on the cycle after the fourth distinct accept. Outputs hold until the next publish.
- `an_err` sets on the cycle after an illegal `s` is first seen.
- `stale` rises exactly 2^TO_W−1 cycles after reset or after the last publish.

## Test plan
1. Normal frame (STABLE=4):
   - Stimulus: scan `an` = 1110/1101/1011/0111, 16 cycles each, with `seg` = 7'h19/7'h30/7'h24/7'h79.
   - Required: one `frame_valid` pulse with D0=4, D1=3, D2=2, D3=1 and `digit_err` = 0.
   - Required: the pulse occurs 1 cycle after the D3 accept at edge 3·16+2+3.
2. Glitch rejection:
   - Stimulus: insert a 3-cycle dwell on `an` = 1101 with `seg` = 7'h00 between normal dwells.
   - Required: D1 is unaffected (stays 3); no extra frame.
3. Illegal anode:
   - Stimulus: hold `an` = 1100 for 10 cycles.
   - Required: `an_err` = 1 persisting, `got` unchanged, no capture.
4. Bad pattern and blank:
   - Stimulus: D2 `seg` = 7'h7E, D3 `seg` = 7'h7F.
   - Required: D2 = 4'hF, D3 = 4'hE, `digit_err` = 4'b0100.
5. Timeout (TO_W=4):
   - Stimulus: stop scanning after one frame.
   - Required: `stale` = 1 exactly 15 cycles after the publish; a new frame clears it.
6. Reset mid-frame:
   - Stimulus: assert `reset` = 0 after D0 and D1 are accepted, then scan D2 and D3 only.
   - Required: all outputs 0 and no `frame_valid` until D0 and D1 are rescanned.
